// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level transforms for the iterative round controller.
// Byte n of a 128-bit state sits at [127-8n -: 8] and maps to row n%4, column n/4.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // MSB bit position of the byte at (row, col) in column-major order.
    function automatic int byte_pos(input int r, input int c);
        return 127 - 8 * (r + 4 * c);
    endfunction

    function automatic int col_pos(input int c);
        return 127 - 32 * c;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                res[byte_pos(r, c) -: 8] = s[byte_pos(r, (c + r) % 4) -: 8];
            end
        end
        return res;
    endfunction

    // One column, row 0 in [31:24]; multiply by the {02,03,01,01} circulant.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Plaintext/ciphertext handshakes plus the key-store and SubBytes side channels.
// master = round controller side, slave = surrounding environment.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic       pt_valid;
    logic       pt_ready;
    aes_state_t pt;
    logic [3:0] rk_idx;
    aes_state_t rk;
    aes_state_t sb_in;
    aes_state_t sb_out;
    logic       ct_valid;
    logic       ct_ready;
    aes_state_t ct;
    logic       busy;

    modport master (
        input  pt_valid, pt, rk, sb_out, ct_ready,
        output pt_ready, rk_idx, sb_in, ct_valid, ct, busy
    );

    modport slave (
        output pt_valid, pt, rk, sb_out, ct_ready,
        input  pt_ready, rk_idx, sb_in, ct_valid, ct, busy
    );

endinterface

// File: rtl/aes_mix_columns.sv
// Combinational MixColumns over the full 128-bit state, one mix_column per column.
module aes_mix_columns
    import aes_pkg::*;
(
    input  aes_state_t din,
    output aes_state_t dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign dout[col_pos(c) -: 32] = mix_column(din[col_pos(c) -: 32]);
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller wrapped around an external combinational SubBytes.
// Optional AES_ROUND_CTRL_ZEROIZE_EN clears the state register once the ciphertext is taken.
module aes_round_ctrl
    import aes_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    aes_round_ctrl_if.master bus
);

    fsm_t       fsm_q, fsm_d;
    aes_state_t state_q, state_d;
    logic [3:0] round_q, round_d;

    aes_state_t sr_out;
    aes_state_t mc_out;
    aes_state_t rnd_out;
    logic       last_round;

    assign last_round = (round_q == 4'(NR));
    assign sr_out     = shift_rows(bus.sb_out);

    aes_mix_columns u_mix_columns (
        .din  (sr_out),
        .dout (mc_out)
    );

    // The final round skips MixColumns.
    assign rnd_out = last_round ? sr_out : mc_out;

    assign bus.sb_in    = state_q;
    assign bus.ct       = state_q;
    assign bus.pt_ready = (fsm_q == IDLE);
    assign bus.ct_valid = (fsm_q == DONE);
    assign bus.busy     = (fsm_q != IDLE);
    assign bus.rk_idx   = (fsm_q == RUN) ? round_q : 4'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // NOTE: every output of this block is given a hold value up front so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        unique case (fsm_q)
            IDLE: begin
                if (bus.pt_valid) begin
                    state_d = bus.pt ^ bus.rk;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = rnd_out ^ bus.rk;
                if (last_round) begin
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.ct_ready) begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
`ifdef AES_ROUND_CTRL_ZEROIZE_EN
                    state_d = '0;
`else
                    state_d = state_q;
`endif
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

endmodule
